// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte stores are queued in a FIFO and serialised onto uart_tx.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_fifo #(
  parameter int CLK_DIV   = 1085,
  parameter int DEPTH     = 16,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_BITS-1:0]     wr_data,
  input  logic                     ovf_clr,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     overflow,
  output logic                     uart_tx
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(CLK_DIV);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 ovf_q, ovf_d;
  state_e               state_q, state_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 push, pop, bit_last;
  logic [DATA_BITS-1:0] head;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;
  assign uart_tx  = tx_q;

  assign head     = mem_q[rd_ptr_q];
  assign bit_last = (bit_q == CW'(CLK_DIV - 1));

  // A write into a full FIFO is dropped even when a pop frees a slot this cycle.
  always_comb begin
    push     = wr_en && !full;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    ovf_d    = ovf_q;
    if (ovf_clr)       ovf_d = 1'b0;
    if (wr_en && full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    // Line is registered off the current state, so it trails the FSM by one cycle.
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        bit_d = bit_q + CW'(1);
        if (bit_last) begin
          bit_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        bit_d = bit_q + CW'(1);
        if (bit_last) begin
          bit_d   = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'(DATA_BITS - 1)) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        bit_d = bit_q + CW'(1);
        if (bit_last) begin
          bit_d   = '0;
          idx_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        bit_d = bit_q + CW'(1);
        if (bit_last) begin
          bit_d = '0;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'(STOP_BITS - 1)) begin
            idx_d = '0;
            if (!empty) begin
              pop     = 1'b1;
              shift_d = head;
`ifdef UART_TX_PARITY_EN
              par_d   = ^head;
`endif
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      bit_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule
